// File: rtl/prefetch_stride_learner.sv
// Stride prefetch learner: watches accepted AR demands inside [bar, limit),
// locks onto a constant stride and issues prefetches up to windowSize ahead.
module prefetch_stride_learner #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned LOG_QUEUE_SIZE  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       s_ar_valid,
  input  logic                       s_ar_ready,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  input  logic [ADDR_BITS-1:0]       bar,
  input  logic [ADDR_BITS-1:0]       limit,
  input  logic [LOG_QUEUE_SIZE:0]    windowSize,
  output logic                       pf_req_valid,
  input  logic                       pf_req_ready,
  output logic [ADDR_BITS-1:0]       pf_req_addr,
  output logic [BURST_LEN_WIDTH-1:0] pf_req_len,
  output logic [TID_WIDTH-1:0]       pf_req_id,
  output logic                       stride_learned,
  output logic [ADDR_BITS-1:0]       stride_reg,
  output logic                       demand_hit
);

  localparam int unsigned WIN_W = LOG_QUEUE_SIZE + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ONE, ST_TWO, ST_LOCKED} state_t;

  state_t                     state, state_n;
  logic [ADDR_BITS-1:0]       last_addr, last_addr_n;
  logic [BURST_LEN_WIDTH-1:0] last_len, last_len_n;
  logic [TID_WIDTH-1:0]       last_id, last_id_n;
  logic [ADDR_BITS-1:0]       stride_n;
  logic [ADDR_BITS-1:0]       demand_pred, demand_pred_n;
  logic [ADDR_BITS-1:0]       next_pf, next_pf_n;
  logic [WIN_W-1:0]           ahead, ahead_n;
  logic                       pf_wrap, pf_wrap_n;
  logic                       valid_n, hit_n, learned_n;

  logic                       demand, same_tag, hit, handshake, stalled;
  logic [ADDR_BITS-1:0]       delta, next_pf_adv, pred_adv, lock_addr;

  // True when step added to base overflowed/underflowed the address space
  function automatic logic add_wraps(input logic [ADDR_BITS-1:0] base,
                                     input logic [ADDR_BITS-1:0] step,
                                     input logic [ADDR_BITS-1:0] sum);
    add_wraps = step[ADDR_BITS-1] ? (sum > base) : (sum < base);
  endfunction

  // Demand qualification and sample comparison against the last latched request
  always_comb begin
    demand    = s_ar_valid & s_ar_ready & en & (s_ar_addr >= bar) & (s_ar_addr < limit);
    delta     = s_ar_addr - last_addr;
    same_tag  = (s_ar_len == last_len) && (s_ar_id == last_id);
    hit       = demand && (state == ST_LOCKED) && same_tag && (s_ar_addr == demand_pred);
    handshake = pf_req_valid & pf_req_ready;
    stalled   = pf_req_valid & ~pf_req_ready;
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_n       = state;
    last_addr_n   = last_addr;
    last_len_n    = last_len;
    last_id_n     = last_id;
    stride_n      = stride_reg;
    demand_pred_n = demand_pred;
    next_pf_n     = next_pf;
    ahead_n       = ahead;
    pf_wrap_n     = pf_wrap;
    valid_n       = pf_req_valid;
    hit_n         = 1'b0;
    next_pf_adv   = next_pf + stride_reg;
    pred_adv      = demand_pred + stride_reg;
    lock_addr     = s_ar_addr + stride_reg;

    if (flush) begin
      state_n = ST_IDLE;
      ahead_n = '0;
      valid_n = 1'b0;
    end else begin
      // Issue/consume bookkeeping; a handshake is honoured even with en low
      // so the controller never sees a request vanish after acceptance.
      if (state == ST_LOCKED) begin
        if (handshake) begin
          next_pf_n = next_pf_adv;
          pf_wrap_n = pf_wrap | add_wraps(next_pf, stride_reg, next_pf_adv);
        end
        if (hit) begin
          hit_n         = 1'b1;
          demand_pred_n = pred_adv;
          last_addr_n   = s_ar_addr;
        end
        case ({handshake, hit})
          2'b10:   ahead_n = ahead + WIN_W'(1);
          2'b01:   ahead_n = (ahead == '0) ? '0 : ahead - WIN_W'(1);
          default: ahead_n = ahead;
        endcase
        // Demand overtook the prefetch pointer: restart issue from the demand
        if ((ahead_n == '0) && !stalled && (next_pf_n != demand_pred_n)) begin
          next_pf_n = demand_pred_n;
          pf_wrap_n = 1'b0;
        end
      end

      if (demand) begin
        case (state)
          ST_IDLE: begin
            state_n     = ST_ONE;
            last_addr_n = s_ar_addr;
            last_len_n  = s_ar_len;
            last_id_n   = s_ar_id;
          end
          ST_ONE: begin
            if (same_tag && (delta != '0)) begin
              state_n  = ST_TWO;
              stride_n = delta;
            end
            last_addr_n = s_ar_addr;
            last_len_n  = s_ar_len;
            last_id_n   = s_ar_id;
          end
          ST_TWO: begin
            if (same_tag && (delta == stride_reg)) begin
              state_n       = ST_LOCKED;
              demand_pred_n = lock_addr;
              next_pf_n     = lock_addr;
              pf_wrap_n     = add_wraps(s_ar_addr, stride_reg, lock_addr);
              ahead_n       = '0;
            end else if (same_tag && (delta != '0)) begin
              state_n  = ST_TWO;
              stride_n = delta;
            end else begin
              state_n = ST_ONE;
            end
            last_addr_n = s_ar_addr;
            last_len_n  = s_ar_len;
            last_id_n   = s_ar_id;
          end
          ST_LOCKED: begin
            if (!hit) begin
              state_n     = ST_ONE;
              last_addr_n = s_ar_addr;
              last_len_n  = s_ar_len;
              last_id_n   = s_ar_id;
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end

      if (state_n != ST_LOCKED) begin
        valid_n = 1'b0;
      end else if (stalled) begin
        valid_n = 1'b1;
      end else begin
        valid_n = en && (ahead_n < windowSize) && !pf_wrap_n &&
                  (next_pf_n >= bar) && (next_pf_n < limit);
      end
    end

    learned_n = (state_n == ST_LOCKED);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr      <= '0;
      last_len       <= '0;
      last_id        <= '0;
      stride_reg     <= '0;
      demand_pred    <= '0;
      next_pf        <= '0;
      ahead          <= '0;
      pf_wrap        <= 1'b0;
      pf_req_valid   <= 1'b0;
      demand_hit     <= 1'b0;
      stride_learned <= 1'b0;
    end else begin
      last_addr      <= last_addr_n;
      last_len       <= last_len_n;
      last_id        <= last_id_n;
      stride_reg     <= stride_n;
      demand_pred    <= demand_pred_n;
      next_pf        <= next_pf_n;
      ahead          <= ahead_n;
      pf_wrap        <= pf_wrap_n;
      pf_req_valid   <= valid_n;
      demand_hit     <= hit_n;
      stride_learned <= learned_n;
    end
  end

  assign pf_req_addr = next_pf;
  assign pf_req_len  = last_len;
  assign pf_req_id   = last_id;

endmodule

// File: tb/tb_prefetch_stride_learner.sv
// Bench for prefetch_stride_learner: expected prefetch addresses are queued as
// demands are driven and compared against observed request handshakes.
module tb_prefetch_stride_learner;

  logic        clk = 1'b0;
  logic        reset, en, flush;
  logic        s_ar_valid, s_ar_ready;
  logic [63:0] s_ar_addr;
  logic [7:0]  s_ar_len, s_ar_id;
  logic [63:0] bar, limit;
  logic [6:0]  windowSize;
  logic        pf_req_valid, pf_req_ready;
  logic [63:0] pf_req_addr;
  logic [7:0]  pf_req_len, pf_req_id;
  logic        stride_learned;
  logic [63:0] stride_reg;
  logic        demand_hit;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];

  prefetch_stride_learner dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
    .bar(bar), .limit(limit), .windowSize(windowSize),
    .pf_req_valid(pf_req_valid), .pf_req_ready(pf_req_ready),
    .pf_req_addr(pf_req_addr), .pf_req_len(pf_req_len), .pf_req_id(pf_req_id),
    .stride_learned(stride_learned), .stride_reg(stride_reg), .demand_hit(demand_hit)
  );

  always #5 clk = ~clk;

  // One clock: note the handshake about to happen, then sample 1 after the edge
  task automatic tick();
    logic        hs;
    logic [63:0] a;
    hs = pf_req_valid && pf_req_ready;
    a  = pf_req_addr;
    @(posedge clk); #1;
    if (hs) obs_q.push_back(a);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_demand(input logic [63:0] a);
    s_ar_valid = 1'b1;
    s_ar_addr  = a;
    tick();
    s_ar_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    ticks(2);
    n_checks++; if (pf_req_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", pf_req_valid); else n_pass++;
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL reset_learned: got %0b want 0", stride_learned); else n_pass++;
    n_checks++; if (stride_reg !== 64'h0) $display("FAIL reset_stride: got %0h want 0", stride_reg); else n_pass++;
    n_checks++; if (pf_req_addr !== 64'h0) $display("FAIL reset_addr: got %0h want 0", pf_req_addr); else n_pass++;
    n_checks++; if (demand_hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", demand_hit); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_learn_window();
    exp_q.push_back(64'h10C0); exp_q.push_back(64'h1100); exp_q.push_back(64'h1140);
    drive_demand(64'h1000);
    drive_demand(64'h1040);
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL learn_early: got %0b want 0", stride_learned); else n_pass++;
    drive_demand(64'h1080);
    n_checks++; if (stride_learned !== 1'b1) $display("FAIL learn_locked: got %0b want 1", stride_learned); else n_pass++;
    n_checks++; if (stride_reg !== 64'h40) $display("FAIL learn_stride: got %0h want 40", stride_reg); else n_pass++;
    n_checks++; if (pf_req_len !== 8'd4 || pf_req_id !== 8'd3)
      $display("FAIL learn_len_id: got len %0d id %0d want len 4 id 3", pf_req_len, pf_req_id); else n_pass++;
    ticks(8);
    n_checks++; if (pf_req_valid !== 1'b0) $display("FAIL learn_stall: got %0b want 0", pf_req_valid); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL learn_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL learn_pf_addr: got %0h want %0h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_demand_hit();
    exp_q.push_back(64'h1180);
    drive_demand(64'h10C0);
    n_checks++; if (demand_hit !== 1'b1) $display("FAIL hit_pulse: got %0b want 1", demand_hit); else n_pass++;
    tick();
    n_checks++; if (demand_hit !== 1'b0) $display("FAIL hit_pulse_end: got %0b want 0", demand_hit); else n_pass++;
    ticks(6);
    n_checks++; if (pf_req_valid !== 1'b0) $display("FAIL hit_stall: got %0b want 0", pf_req_valid); else n_pass++;
    n_checks++; if (stride_learned !== 1'b1) $display("FAIL hit_locked: got %0b want 1", stride_learned); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL hit_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL hit_pf_addr: got %0h want %0h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_negative_stride();
    do_flush();
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL neg_flush: got %0b want 0", stride_learned); else n_pass++;
    exp_q.push_back(64'h1F40); exp_q.push_back(64'h1F00); exp_q.push_back(64'h1EC0);
    drive_demand(64'h2000);
    drive_demand(64'h1FC0);
    drive_demand(64'h1F80);
    n_checks++; if (stride_reg !== 64'hFFFF_FFFF_FFFF_FFC0)
      $display("FAIL neg_stride: got %0h want ffffffffffffffc0", stride_reg); else n_pass++;
    ticks(8);
    n_checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL neg_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL neg_pf_addr: got %0h want %0h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_window_limit();
    limit = 64'h1100;
    do_flush();
    exp_q.push_back(64'h10C0);
    drive_demand(64'h1000);
    drive_demand(64'h1040);
    drive_demand(64'h1080);
    ticks(6);
    n_checks++; if (pf_req_valid !== 1'b0) $display("FAIL limit_valid: got %0b want 0", pf_req_valid); else n_pass++;
    n_checks++; if (stride_learned !== 1'b1) $display("FAIL limit_locked: got %0b want 1", stride_learned); else n_pass++;
    n_checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL limit_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL limit_pf_addr: got %0h want %0h", o, e); else n_pass++;
    end
    limit = 64'h1_0000;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall_and_miss();
    do_flush();
    pf_req_ready = 1'b0;
    drive_demand(64'h3000);
    drive_demand(64'h3040);
    drive_demand(64'h3080);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (pf_req_valid !== 1'b1 || pf_req_addr !== 64'h30C0)
        $display("FAIL stall_hold: got valid %0b addr %0h want valid 1 addr 30c0", pf_req_valid, pf_req_addr); else n_pass++;
      tick();
    end
    drive_demand(64'h5000);
    n_checks++; if (pf_req_valid !== 1'b0) $display("FAIL miss_valid: got %0b want 0", pf_req_valid); else n_pass++;
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL miss_unlock: got %0b want 0", stride_learned); else n_pass++;
    n_checks++; if (obs_q.size() !== 0) $display("FAIL stall_no_issue: got %0d want 0", obs_q.size()); else n_pass++;
    pf_req_ready = 1'b1;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush_priority();
    flush = 1'b1;
    s_ar_valid = 1'b1; s_ar_addr = 64'h4000;
    tick();
    flush = 1'b0; s_ar_valid = 1'b0;
    exp_q.delete(); obs_q.delete();
    n_checks++; if (stride_learned !== 1'b0 || pf_req_valid !== 1'b0)
      $display("FAIL flush_clear: got learned %0b valid %0b want 0 0", stride_learned, pf_req_valid); else n_pass++;
    exp_q.push_back(64'h4100); exp_q.push_back(64'h4140); exp_q.push_back(64'h4180);
    drive_demand(64'h4040);
    drive_demand(64'h4080);
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL flush_priority: got %0b want 0", stride_learned); else n_pass++;
    drive_demand(64'h40C0);
    n_checks++; if (stride_learned !== 1'b1) $display("FAIL flush_relock: got %0b want 1", stride_learned); else n_pass++;
    ticks(8);
    n_checks++; if (obs_q.size() !== exp_q.size())
      $display("FAIL flush_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [63:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) $display("FAIL flush_pf_addr: got %0h want %0h", o, e); else n_pass++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    do_flush();
    pf_req_ready = 1'b0;
    drive_demand(64'h6000);
    drive_demand(64'h6040);
    drive_demand(64'h6080);
    n_checks++; if (pf_req_valid !== 1'b1) $display("FAIL areset_pre: got %0b want 1", pf_req_valid); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pf_req_valid !== 1'b0 || stride_learned !== 1'b0 || demand_hit !== 1'b0)
      $display("FAIL areset_flags: got valid %0b learned %0b hit %0b want 0 0 0", pf_req_valid, stride_learned, demand_hit); else n_pass++;
    n_checks++; if (pf_req_addr !== 64'h0 || stride_reg !== 64'h0 || pf_req_len !== 8'h0 || pf_req_id !== 8'h0)
      $display("FAIL areset_fields: got addr %0h stride %0h len %0h id %0h want 0", pf_req_addr, stride_reg, pf_req_len, pf_req_id); else n_pass++;
    tick();
    reset = 1'b0;
    pf_req_ready = 1'b1;
    drive_demand(64'h7000);
    drive_demand(64'h7040);
    n_checks++; if (stride_learned !== 1'b0) $display("FAIL areset_restart: got %0b want 0", stride_learned); else n_pass++;
    drive_demand(64'h7080);
    n_checks++; if (stride_learned !== 1'b1 || stride_reg !== 64'h40)
      $display("FAIL areset_relock: got learned %0b stride %0h want 1 40", stride_learned, stride_reg); else n_pass++;
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    s_ar_valid = 1'b0; s_ar_ready = 1'b1; s_ar_addr = '0;
    s_ar_len = 8'd4; s_ar_id = 8'd3;
    bar = 64'h0; limit = 64'h1_0000; windowSize = 7'd3;
    pf_req_ready = 1'b1;
    test_reset();
    test_learn_window();
    test_demand_hit();
    test_negative_stride();
    test_window_limit();
    test_stall_and_miss();
    test_flush_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
